decod_varredura: RTL and testbench
==================================

DECOD_VARREDURA -- requirements
Module: decod_varredura

Interface
REQ-001 The block SHALL have parameter LARGURA, default 4, giving the select/index width (1..8).
REQ-002 The block SHALL have parameter PERIODO, default 4, giving the clock cycles per scan step (>=1).
REQ-003 The block SHALL have port Clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1, asynchronous, active-high reset.
REQ-005 The block SHALL have port Habilita, input, 1, block enable; 0 forces the idle state.
REQ-006 The block SHALL have port Modo, input, 1, mode select: 0 = direct decode, 1 = auto-scan.
REQ-007 The block SHALL have port Entrada, input, LARGURA, the index to decode in direct mode.
REQ-008 The block SHALL have port Valido, input, 1, the Entrada-valid strobe for the handshake.
REQ-009 The block SHALL have port Pronto, output, 1, ready; registered; 1 when a direct-mode transfer can be accepted.
REQ-010 The block SHALL have port Saida, output, 2**LARGURA, the registered one-hot decoded output.
REQ-011 The block SHALL have port Indice, output, LARGURA, the registered currently selected index.
REQ-012 The block SHALL have port Volta, output, 1, a one-cycle pulse on scan wrap-around.

Function
REQ-013 The FSM SHALL have three states: OCIOSO (Saida all inactive), DIRETO (holding a decoded value) and VARRE (auto-scan).
REQ-014 Pronto SHALL be 1 in OCIOSO and DIRETO and 0 in VARRE.
REQ-015 A transfer SHALL be accepted on a cycle where Habilita=1, Modo=0, Valido=1 and Pronto=1.
REQ-016 On acceptance: next cycle Indice=Entrada, Saida one-hot at bit Entrada, state DIRETO; latency 1 cycle.
REQ-017 Back-to-back transfers SHALL be accepted every cycle with no bubble.
REQ-018 In DIRETO, Saida and Indice SHALL hold until the next accepted transfer, Habilita=0, or Modo=1.
REQ-019 Valido with Habilita=0 or Modo=1 SHALL be ignored (no state change caused by Entrada).
REQ-020 Habilita=1 and Modo=1 from OCIOSO/DIRETO SHALL enter VARRE next cycle with Indice=0, Saida[0] active and the prescaler cleared.
REQ-021 In VARRE, the prescaler SHALL count 0..PERIODO-1; at PERIODO-1, Indice SHALL increment modulo 2**LARGURA and the prescaler return to 0; each index is held exactly PERIODO cycles.
REQ-022 Volta SHALL be 1 for exactly the first cycle in which Indice=0 after wrapping from 2**LARGURA-1, and 0 on VARRE entry and in all other cycles.
REQ-023 From VARRE, Modo=0 (Habilita=1) SHALL go to OCIOSO next cycle: Saida inactive, Indice=0, Pronto=1; a Valido in that same cycle is ignored.
REQ-024 Habilita=0 SHALL have priority over all other inputs: next cycle OCIOSO, Saida inactive, Indice=0, Volta=0, prescaler cleared.
REQ-025 Saida SHALL be one-hot of Indice in DIRETO and VARRE and all-inactive in OCIOSO; never more than one bit active.

Reset
REQ-026 Reset=1 SHALL immediately (asynchronously) force state OCIOSO, Saida inactive, Indice=0, Volta=0, Pronto=1 and prescaler 0.
REQ-027 Reset asserted mid-scan or mid-transfer SHALL discard all progress; after release, the first edge behaves as from OCIOSO.

Configuration
REQ-028 Macro DECOD_VARREDURA_ATIVO_BAIXO_EN defined SHALL make Saida active-low: inactive = all ones, selected bit = 0, including reset value.
REQ-029 Without DECOD_VARREDURA_ATIVO_BAIXO_EN, Saida SHALL be active-high: inactive = all zeros, selected bit = 1; all other behaviour is identical in both builds.

Verification (LARGURA=4, PERIODO=3, active-high unless noted)
REQ-030 Reset mid-scan with Indice=5 -> same cycle Saida=16'h0000, Indice=0, Pronto=1, Volta=0.
REQ-031 Modo=0, Habilita=1, Valido=1, Entrada=9, then 12, then 3 on consecutive cycles -> Saida=16'h0200, 16'h1000, 16'h0008 on the following consecutive cycles with Pronto=1 throughout.
REQ-032 Modo=1, Habilita=1 held 50 cycles -> Indice 0,1,2,... each held 3 cycles; Volta=1 only in the first cycle of Indice=0 after Indice=15 (cycle 48 after entry); Pronto=0.
REQ-033 Scanning at Indice=7 with Modo set to 0 and Valido=1, Entrada=2 in the same cycle -> next cycle Saida=0, Pronto=1; Entrada=2 accepted one cycle later gives Saida=16'h0004.
REQ-034 Habilita=0 while in DIRETO with Entrada=4 -> next cycle Saida=0, Indice=0; Valido pulses ignored while Habilita=0.
REQ-035 With DECOD_VARREDURA_ATIVO_BAIXO_EN, accepting Entrada=0 -> Saida=16'hFFFE; after reset, Saida=16'hFFFF.

Source files
------------

// File: rtl/decod_varredura_if.sv
// Bus between the decoder/scanner and its user.
// The master drives the controls and the index. The slave (the decoder) returns
// the ready flag, the decoded word, the current index and the wrap pulse.
interface decod_varredura_if #(
  parameter int unsigned LARGURA = 4
);
  localparam int unsigned N_SAIDA = 2 ** LARGURA;

  logic               Habilita;
  logic               Modo;
  logic [LARGURA-1:0] Entrada;
  logic               Valido;
  logic               Pronto;
  logic [N_SAIDA-1:0] Saida;
  logic [LARGURA-1:0] Indice;
  logic               Volta;

  modport master (
    output Habilita, Modo, Entrada, Valido,
    input  Pronto, Saida, Indice, Volta
  );

  modport slave (
    input  Habilita, Modo, Entrada, Valido,
    output Pronto, Saida, Indice, Volta
  );
endinterface

// File: rtl/decod_varredura.sv
// One-hot decoder with a direct-decode mode and an auto-scan mode.
// In direct mode, the index is taken with a valid/ready handshake.
// In auto-scan mode, the index steps every PERIODO cycles.
// Build option: DECOD_VARREDURA_ATIVO_BAIXO_EN makes Saida active-low.
module decod_varredura #(
  parameter int unsigned LARGURA = 4,
  parameter int unsigned PERIODO = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  decod_varredura_if.slave     bus
);

  localparam int unsigned N_SAIDA = 2 ** LARGURA;
  localparam int unsigned PW      = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [LARGURA-1:0] IDX_MAX = LARGURA'((2 ** LARGURA) - 1);

`ifdef DECOD_VARREDURA_ATIVO_BAIXO_EN
  localparam logic [N_SAIDA-1:0] INATIVO = '1;
`else
  localparam logic [N_SAIDA-1:0] INATIVO = '0;
`endif

  typedef enum logic [1:0] {OCIOSO, DIRETO, VARRE} estado_t;

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] indice_q, indice_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [N_SAIDA-1:0] saida_q, saida_d;
  logic               volta_q, volta_d;
  logic               pronto_q, pronto_d;

  // State and registered outputs; reset forces the idle picture at once
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= OCIOSO;
      indice_q <= '0;
      presc_q  <= '0;
      saida_q  <= INATIVO;
      volta_q  <= 1'b0;
      pronto_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      indice_q <= indice_d;
      presc_q  <= presc_d;
      saida_q  <= saida_d;
      volta_q  <= volta_d;
      pronto_q <= pronto_d;
    end
  end

  // Next state; priority order is disable, then scan request, then direct transfer
  always_comb begin
    state_d  = state_q;
    indice_d = indice_q;
    presc_d  = presc_q;
    volta_d  = 1'b0;

    if (!bus.Habilita) begin
      state_d  = OCIOSO;
      indice_d = '0;
      presc_d  = '0;
    end else if (bus.Modo) begin
      if (state_q != VARRE) begin
        state_d  = VARRE;
        indice_d = '0;
        presc_d  = '0;
      end else if (presc_q == PW'(PERIODO - 1)) begin
        presc_d  = '0;
        indice_d = indice_q + LARGURA'(1);
        volta_d  = (indice_q == IDX_MAX);
      end else begin
        presc_d  = presc_q + PW'(1);
      end
    end else if (state_q == VARRE) begin
      // Leaving the scan goes through idle; any Valido in this cycle is ignored
      state_d  = OCIOSO;
      indice_d = '0;
      presc_d  = '0;
    end else if (bus.Valido && pronto_q) begin
      state_d  = DIRETO;
      indice_d = bus.Entrada;
      presc_d  = '0;
    end

    pronto_d = (state_d != VARRE);
    if (state_d == OCIOSO) begin
      saida_d = INATIVO;
    end else begin
      saida_d = INATIVO ^ (N_SAIDA'(1) << indice_d);
    end
  end

  assign bus.Pronto = pronto_q;
  assign bus.Saida  = saida_q;
  assign bus.Indice = indice_q;
  assign bus.Volta  = volta_q;

endmodule

// File: tb/tb_decod_varredura.sv
// Directed bench for decod_varredura with LARGURA=4 and PERIODO=3.
// Expected decoded values are written active-high. They are inverted when the
// DECOD_VARREDURA_ATIVO_BAIXO_EN build is selected.
module tb_decod_varredura;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  decod_varredura_if #(.LARGURA(4)) bus ();

  decod_varredura #(.LARGURA(4), .PERIODO(3)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hab;
    logic        modo;
    logic        val;
    logic [3:0]  ent;
    logic [15:0] e_saida;
    logic [3:0]  e_indice;
    logic        e_pronto;
    logic        e_volta;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [15:0] nivel(input logic [15:0] ativo_alto);
`ifdef DECOD_VARREDURA_ATIVO_BAIXO_EN
    return ~ativo_alto;
`else
    return ativo_alto;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic h, input logic m, input logic v, input logic [3:0] e);
    bus.Habilita = h;
    bus.Modo     = m;
    bus.Valido   = v;
    bus.Entrada  = e;
  endtask

  task automatic chk(input string nome, input logic [15:0] s, input logic [3:0] i,
                     input logic p, input logic vo);
    logic [15:0] es;
    es = nivel(s);
    n_checks++;
    if (bus.Saida !== es || bus.Indice !== i || bus.Pronto !== p || bus.Volta !== vo) begin
      n_fail++;
      $display("FAIL %s: got Saida=%h Indice=%0d Pronto=%b Volta=%b, expected Saida=%h Indice=%0d Pronto=%b Volta=%b",
               nome, bus.Saida, bus.Indice, bus.Pronto, bus.Volta, es, i, p, vo);
    end
  endtask

  initial begin
    int k;
    int idx;
    logic [15:0] oh;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 4'd9,  16'h0200, 4'd9,  1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'd12, 16'h1000, 4'd12, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd3,  16'h0008, 4'd3,  1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd5,  16'h0008, 4'd3,  1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd4,  16'h0010, 4'd4,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd7,  16'h0000, 4'd0,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd8,  16'h0000, 4'd0,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 4'd6,  16'h0000, 4'd0,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'd6,  16'h0001, 4'd0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 4'd6,  16'h0001, 4'd0,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 4'd6,  16'h0001, 4'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'd6,  16'h0002, 4'd1,  1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 4'd2,  16'h0000, 4'd0,  1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 4'd2,  16'h0004, 4'd2,  1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'd15, 16'h8000, 4'd15, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    #1;
    chk("reset", 16'h0000, 4'd0, 1'b1, 1'b0);
    #12;
    rst = 1'b0;
    tick();
    chk("idle_after_reset", 16'h0000, 4'd0, 1'b1, 1'b0);

    // Vector table: transfers, hold, disable, scan entry, scan exit
    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].hab, vecs[v].modo, vecs[v].val, vecs[v].ent);
      tick();
      chk($sformatf("vec%0d", v), vecs[v].e_saida, vecs[v].e_indice,
          vecs[v].e_pronto, vecs[v].e_volta);
    end

    // 50 cycles of scanning starting from the idle state
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (k = 0; k < 50; k++) begin
      tick();
      idx = (k / 3) % 16;
      oh  = 16'h0001 << idx;
      chk($sformatf("scan_k%0d", k), oh, 4'(idx), 1'b0, (k == 48));
    end

    // Leave the scan at index 7 with a Valido in the same cycle
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (k = 0; k < 22; k++) tick();
    chk("scan_at7", 16'h0080, 4'd7, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 4'd2);
    tick();
    chk("scan_exit", 16'h0000, 4'd0, 1'b1, 1'b0);
    tick();
    chk("after_exit_accept", 16'h0004, 4'd2, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a scan at index 5
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'd0);
    for (k = 0; k < 16; k++) tick();
    chk("scan_at5", 16'h0020, 4'd5, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 16'h0000, 4'd0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 4'd1);
    tick();
    chk("post_reset_accept", 16'h0002, 4'd1, 1'b1, 1'b0);

    // Index 0 boundary in direct mode
    drive(1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    chk("direct_idx0", 16'h0001, 4'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
